mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage initiator for the byte-lane data RAM port (ce/we/addr/byte_selected/wdata/rdata).
//  Converts a load/store request (byte/half/word, signed/unsigned) into one or two
//  word-aligned RAM accesses with lane masks and wdata shifting.
//  Splits word-crossing accesses in two; merges, extracts and sign/zero-extends load data.
//  Stalls the pipeline until the response is delivered.
// PARAMETERS
//  ADDR_W       32  byte address width; RAM word index = addr[ADDR_W-1:2]
//  MISALIGN_EN  1   1: split word-crossing accesses; 0: reject them with resp_err
// PORTS
//  clk           in   1   clock; all state changes on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   1 only in IDLE with rst_n high; accept = req_valid & req_ready
//  req_we        in   1   1 store, 0 load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   load zero-extend (1) / sign-extend (0); ignored for stores
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32  store data, right-justified
//  resp_valid    out  1   one-cycle pulse: request complete
//  resp_rdata    out  32  load result, valid with resp_valid; 0 for stores and errors
//  resp_err      out  1   with resp_valid: illegal size, or misaligned when MISALIGN_EN=0
//  stall_o       out  1   = ~IDLE; holds the pipeline
//  ram_ce        out  1   RAM chip enable
//  ram_we        out  1   RAM write enable; write commits on the posedge ending the cycle
//  ram_addr      out  ADDR_W  word address, low two bits always 00
//  ram_byte_sel  out  4   lane mask; bit n enables wdata[8n+7:8n]
//  ram_wdata     out  32  lane-positioned store data
//  ram_rdata     in   32  RAM read data, combinational from ram_addr while ce=1, we=0
// BEHAVIOUR
//  Reset (async): state IDLE; request/lo/hi regs 0; every output 0 (req_ready 0 while rst_n low).
//  FSM: IDLE -accept-> ACC1 (err: -> RESP). ACC1 -cross-> ACC2, else -> RESP. ACC2 -> RESP. RESP -> IDLE.
//  On accept, latch we/size/unsigned/addr/wdata; later req_* changes have no effect.
//  off = addr[1:0]; nbytes = 1/2/4; mask = 0001/0011/1111; cross = off+nbytes > 4.
//  err = (size==11) | (cross & ~MISALIGN_EN); no RAM cycle ever issued for err.
//  ACC1: ce=1, we=req_we, addr={addr[ADDR_W-1:2],00}, sel=(mask<<off)[3:0],
//        wdata=({32'b0,wdata}<<8*off)[31:0]; load: lo <= ram_rdata at posedge.
//  ACC2: addr=word+1 (wraps to 0 at top of space), sel=(mask<<off)[7:4],
//        wdata=({32'b0,wdata}<<8*off)[63:32]; load: hi <= ram_rdata.
//  Lanes with sel=0 carry wdata 0. Loads drive we=0 with sel=mask lanes.
//  Outside ACC1/ACC2: ce=0, we=0, addr=0, sel=0, wdata=0.
//  RESP: resp_valid=1; rdata = ({hi,lo}>>8*off) truncated to nbytes, then extended.
//  Latency accept->resp_valid: aligned 2 cycles, crossing 3, err 1; next accept earliest 1 cycle after RESP.
//  Reset mid-operation: abort immediately, no response. Half of a split store already
//  committed in ACC1 stays written; there is no rollback.
// STRUCTURE
//  defines.v: size codes (SizeByte/SizeHalf/SizeWord), FSM state codes, ChipEnable/WriteEnable,
//  ZeroWord, DataBus.
//  One combinational sub-module, mem_lane_align: mask/wdata shift, {hi,lo} merge, extension.
// TESTING  (RAM preload: word 0x0=0x44332211, word 0x4=0x88776655)
//  LW 0x0 -> one RAM cycle sel=1111; resp_rdata=0x44332211 at accept+2, err=0.
//  LB 0x7 signed -> 0xFFFFFF88; LBU 0x7 -> 0x00000088; LH 0x2 -> 0x00004433.
//  LW 0x3 -> reads 0x0 then 0x4; resp_rdata=0x77665544 at accept+3; stall_o high 3 cycles.
//  SH 0x3 data 0xBEEF -> ACC1 addr 0x0 sel 1000 wdata 0xEF000000; ACC2 addr 0x4 sel 0001
//    wdata 0x000000BE; reload gives 0xEF332211 / 0x887766BE.
//  MISALIGN_EN=0, LW 0x2 -> resp_err=1 and rdata=0 at accept+1; ram_ce never asserted.
//    Size 11 -> same, for any MISALIGN_EN.
//  rst_n low during ACC2 of SW 0x1 -> outputs 0 at once; no resp_valid; word 0x4 unchanged.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data RAM access controller.
// Holds the access-size codes, FSM state codes, RAM control constants and
// small helpers that turn a size code into a lane mask / byte count.
package mem_access_ctrl_pkg;

  localparam int          DATA_BUS     = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC1 = 2'b01,
    ST_ACC2 = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Right-justified lane mask for one access of the given size.
  function automatic logic [3:0] size_mask(input size_e size);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001;
      SIZE_HALF: mask = 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic [2:0] size_nbytes(input size_e size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

  // An access crosses a word boundary when its last byte lands past lane 3.
  function automatic logic size_cross(input logic [1:0] off, input size_e size);
    return (({1'b0, off} + size_nbytes(size)) > 3'd4);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response bundle of the MEM-stage access controller.
//   master : the pipeline (drives req_*, observes req_ready/resp_*/stall_o)
//   slave  : mem_access_ctrl
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall_o;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall_o
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall_o
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for mem_access_ctrl.
//   size/off/is_unsigned : latched access description
//   wdata                : right-justified store data
//   lo/hi                : first/second RAM read words
//   sel8                 : lane mask over two consecutive words ([3:0] first word)
//   wdata64              : store data positioned over the same two words
//   rdata                : extracted and extended load result
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  sel8,
  output logic [63:0] wdata64,
  output logic [31:0] rdata
);
  logic [3:0]  mask_s;
  logic [31:0] wmask_s;
  logic [4:0]  shamt_s;
  logic [31:0] raw_s;

  assign mask_s  = size_mask(size);
  assign shamt_s = {off, 3'b000};
  assign sel8    = {4'b0000, mask_s} << off;

  // Bytes beyond the access size are cleared so unselected lanes carry zero.
  assign wmask_s = {{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}};
  assign wdata64 = {32'h0000_0000, wdata & wmask_s} << shamt_s;

  assign raw_s = DATA_BUS'({hi, lo} >> shamt_s);

  // Truncate to the access size, then sign- or zero-extend.
  always_comb begin
    rdata = ZERO_WORD;
    case (size)
      SIZE_BYTE: rdata = {{24{~is_unsigned & raw_s[7]}}, raw_s[7:0]};
      SIZE_HALF: rdata = {{16{~is_unsigned & raw_s[15]}}, raw_s[15:0]};
      default:   rdata = raw_s;
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for a byte-lane data RAM.
// Turns one load/store request into one or two word-aligned RAM cycles and
// returns a single-cycle response; stall_o holds the pipeline meanwhile.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : request/response handshake (slave side)
//   ram_ce/ram_we  : RAM chip/write enable
//   ram_addr       : word-aligned byte address
//   ram_byte_sel   : lane mask
//   ram_wdata      : lane-positioned store data
//   ram_rdata      : combinational read data
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
)(
  input  logic                clk,
  input  logic                rst_n,
  mem_access_ctrl_if.slave    bus,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [3:0]          ram_byte_sel,
  output logic [DATA_BUS-1:0] ram_wdata,
  input  logic [DATA_BUS-1:0] ram_rdata
);
  state_e            state_r, state_s;
  logic              we_r, uns_r, cross_r, err_r;
  size_e             size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r, lo_r, hi_r;
  logic              accept_s, in_cross_s, in_err_s;
  logic [7:0]        sel8_s;
  logic [63:0]       wdata64_s;
  logic [31:0]       rdata_s;

  // rst_n is folded in so the port reads 0 while reset is held.
  assign bus.req_ready = (state_r == ST_IDLE) & rst_n;
  assign bus.stall_o   = (state_r != ST_IDLE);
  assign accept_s      = bus.req_valid & bus.req_ready;
  assign in_cross_s    = size_cross(bus.req_addr[1:0], size_e'(bus.req_size));
  assign in_err_s      = (size_e'(bus.req_size) == SIZE_ILL) | (in_cross_s & ~MISALIGN_EN);

  mem_lane_align u_align (
    .size        (size_r),
    .off         (addr_r[1:0]),
    .is_unsigned (uns_r),
    .wdata       (wdata_r),
    .lo          (lo_r),
    .hi          (hi_r),
    .sel8        (sel8_s),
    .wdata64     (wdata64_s),
    .rdata       (rdata_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; rejected requests skip the RAM entirely.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = in_err_s ? ST_RESP : ST_ACC1;
        else          state_s = ST_IDLE;
      end
      ST_ACC1: state_s = cross_r ? ST_ACC2 : ST_RESP;
      ST_ACC2: state_s = ST_RESP;
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request capture on accept; later req_* changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      cross_r <= 1'b0;
      err_r   <= 1'b0;
      size_r  <= SIZE_BYTE;
      addr_r  <= '0;
      wdata_r <= ZERO_WORD;
    end else if (accept_s) begin
      we_r    <= bus.req_we;
      uns_r   <= bus.req_unsigned;
      cross_r <= in_cross_s;
      err_r   <= in_err_s;
      size_r  <= size_e'(bus.req_size);
      addr_r  <= bus.req_addr;
      wdata_r <= bus.req_wdata;
    end
  end

  // Load data capture: first word in ACC1, second word in ACC2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_r <= ZERO_WORD;
      hi_r <= ZERO_WORD;
    end else if (state_r == ST_ACC1 && !we_r) begin
      lo_r <= ram_rdata;
    end else if (state_r == ST_ACC2 && !we_r) begin
      hi_r <= ram_rdata;
    end
  end

  // RAM port drive; the second word address wraps naturally at the top.
  always_comb begin
    ram_ce       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_byte_sel = 4'b0000;
    ram_wdata    = ZERO_WORD;
    case (state_r)
      ST_ACC1: begin
        ram_ce       = CHIP_ENABLE;
        ram_we       = (we_r == WRITE_ENABLE);
        ram_addr     = {addr_r[ADDR_W-1:2], 2'b00};
        ram_byte_sel = sel8_s[3:0];
        ram_wdata    = wdata64_s[31:0];
      end
      ST_ACC2: begin
        ram_ce       = CHIP_ENABLE;
        ram_we       = (we_r == WRITE_ENABLE);
        ram_addr     = {addr_r[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
        ram_byte_sel = sel8_s[7:4];
        ram_wdata    = wdata64_s[63:32];
      end
      default: begin
        ram_ce = 1'b0;
      end
    endcase
  end

  // Response: stores and errors return zero data.
  always_comb begin
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = ZERO_WORD;
    if (state_r == ST_RESP) begin
      bus.resp_valid = 1'b1;
      bus.resp_err   = err_r;
      if (!we_r && !err_r) bus.resp_rdata = rdata_s;
      else                 bus.resp_rdata = ZERO_WORD;
    end else begin
      bus.resp_valid = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, self-checking bench for mem_access_ctrl with a response scoreboard.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();
  mem_access_ctrl_if #(.ADDR_W(32)) bus0 ();

  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_byte_sel;
  logic        ram0_ce, ram0_we;
  logic [31:0] ram0_addr, ram0_wdata, ram0_rdata;
  logic [3:0]  ram0_byte_sel;

  logic [31:0] mem [16];
  exp_t        exp_q [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_sel [$];
  logic [31:0] log_wdata [$];
  logic [31:0] log_we [$];

  mem_access_ctrl #(.ADDR_W(32), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_byte_sel(ram_byte_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_access_ctrl #(.ADDR_W(32), .MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .ram_ce(ram0_ce), .ram_we(ram0_we), .ram_addr(ram0_addr),
    .ram_byte_sel(ram0_byte_sel), .ram_wdata(ram0_wdata), .ram_rdata(ram0_rdata)
  );

  assign ram_rdata  = mem[ram_addr[5:2]];
  assign ram0_rdata = 32'h5A6B7C8D;

  // Byte-lane RAM model, 16 words aliased over the address space.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0000_0000;
      mem[0]  <= 32'h44332211;
      mem[1]  <= 32'h88776655;
      mem[15] <= 32'hAB000000;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_byte_sel[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cyc(input string tag, input int idx, input logic we,
                           input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
    check({tag, "_we"},    log_we[idx],    32'(we));
    check({tag, "_addr"},  log_addr[idx],  addr);
    check({tag, "_sel"},   log_sel[idx],   32'(sel));
    check({tag, "_wdata"}, log_wdata[idx], wdata);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_ncyc);
    exp_t e;
    int   cyc;
    int   stall;
    logic got;
    logic [31:0] r_rdata;
    logic r_err;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    log_addr.delete(); log_sel.delete(); log_wdata.delete(); log_we.delete();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_size = ~size;
    bus.req_unsigned = ~uns; bus.req_addr = ~addr; bus.req_wdata = ~wdata;
    cyc = 0; stall = 0; got = 1'b0; r_rdata = 32'h0; r_err = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.stall_o) stall++;
      if (ram_ce) begin
        log_addr.push_back(ram_addr); log_sel.push_back(32'(ram_byte_sel));
        log_wdata.push_back(ram_wdata); log_we.push_back(32'(ram_we));
      end
      if (bus.resp_valid) begin
        got = 1'b1; r_rdata = bus.resp_rdata; r_err = bus.resp_err;
      end
    end
    check({tag, "_lat"},   32'(cyc),   32'(exp_lat));
    check({tag, "_stall"}, 32'(stall), 32'(exp_lat));
    check({tag, "_ncyc"},  32'(log_addr.size()), 32'(exp_ncyc));
    e = exp_q.pop_front();
    check({tag, "_rdata"}, r_rdata, e.rdata);
    check({tag, "_err"},   32'(r_err), 32'(e.err));
    @(negedge clk);
    check({tag, "_idle"},  {30'b0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask

  task automatic do_req0(input string tag, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_ncyc);
    int   cyc;
    int   nce;
    logic got;
    logic [31:0] r_rdata;
    logic r_err;
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_size = size;
    bus0.req_unsigned = 1'b0; bus0.req_addr = addr; bus0.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    cyc = 0; nce = 0; got = 1'b0; r_rdata = 32'h0; r_err = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (ram0_ce) nce++;
      if (bus0.resp_valid) begin
        got = 1'b1; r_rdata = bus0.resp_rdata; r_err = bus0.resp_err;
      end
    end
    check({tag, "_lat"},   32'(cyc), 32'(exp_lat));
    check({tag, "_ncyc"},  32'(nce), 32'(exp_ncyc));
    check({tag, "_rdata"}, r_rdata, exp_rdata);
    check({tag, "_err"},   32'(r_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nresp;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_size = 2'b00;
    bus0.req_unsigned = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_ctl", {26'b0, ram_ce, ram_we, bus.resp_valid, bus.resp_err, bus.stall_o, bus0.stall_o}, 32'd0);
    check("rst_sel", {24'b0, ram_byte_sel, ram0_byte_sel}, 32'd0);
    check("rst_addr", ram_addr | ram0_addr | ram_wdata | ram0_wdata | bus.resp_rdata, 32'd0);
    check("rst_ram0", {30'b0, ram0_ce, ram0_we}, 32'd0);
    rst_n = 1'b1;
    preload = 1'b0;

    do_req("lw0",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h44332211, 1'b0, 2, 1);
    check_cyc("lw0_c0", 0, 1'b0, 32'h0, 4'b1111, 32'h0);
    do_req("lb7",  1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1);
    check_cyc("lb7_c0", 0, 1'b0, 32'h4, 4'b1000, 32'h0);
    do_req("lbu7", 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'h00000088, 1'b0, 2, 1);
    do_req("lh2",  1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'h00004433, 1'b0, 2, 1);
    check_cyc("lh2_c0", 0, 1'b0, 32'h0, 4'b1100, 32'h0);
    do_req("lw3",  1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 32'h77665544, 1'b0, 3, 2);
    check_cyc("lw3_c0", 0, 1'b0, 32'h0, 4'b1000, 32'h0);
    check_cyc("lw3_c1", 1, 1'b0, 32'h4, 4'b0111, 32'h0);
    do_req("lh3",  1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h00005544, 1'b0, 3, 2);

    do_req("sh3",  1'b1, 2'b01, 1'b0, 32'h3, 32'hDEADBEEF, 32'h0, 1'b0, 3, 2);
    check_cyc("sh3_c0", 0, 1'b1, 32'h0, 4'b1000, 32'hEF000000);
    check_cyc("sh3_c1", 1, 1'b1, 32'h4, 4'b0001, 32'h000000BE);
    do_req("rd0a", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hEF332211, 1'b0, 2, 1);
    do_req("rd4a", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h887766BE, 1'b0, 2, 1);

    do_req("sb5",  1'b1, 2'b00, 1'b0, 32'h5, 32'h123456A5, 32'h0, 1'b0, 2, 1);
    check_cyc("sb5_c0", 0, 1'b1, 32'h4, 4'b0010, 32'h0000A500);
    do_req("lh6",  1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFF8877, 1'b0, 2, 1);
    do_req("rd4b", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8877A5BE, 1'b0, 2, 1);

    do_req("wrap", 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h000011AB, 1'b0, 3, 2);
    check_cyc("wrap_c0", 0, 1'b0, 32'hFFFFFFFC, 4'b1000, 32'h0);
    check_cyc("wrap_c1", 1, 1'b0, 32'h0, 4'b0001, 32'h0);

    do_req("ill",  1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("ills", 1'b1, 2'b11, 1'b0, 32'h4, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);

    do_req0("m0_lw2", 2'b10, 32'h2, 32'h0, 1'b1, 1, 0);
    do_req0("m0_ill", 2'b11, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req0("m0_lb1", 2'b00, 32'h1, 32'h0000007C, 1'b0, 2, 1);
    do_req0("m0_lw0", 2'b10, 32'h0, 32'h5A6B7C8D, 1'b0, 2, 1);

    // Reset during the second half of a split store.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h1; bus.req_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rsw_acc1", {ram_we, ram_byte_sel, ram_addr[26:0]}, {1'b1, 4'b1110, 27'h0});
    check("rsw_acc1_wd", ram_wdata, 32'hB2C3D400);
    @(negedge clk);
    check("rsw_acc2", {ram_ce, ram_byte_sel, ram_addr[26:0]}, {1'b1, 4'b0001, 27'h4});
    rst_n = 1'b0;
    #1;
    check("rsw_outs", {25'b0, ram_ce, ram_we, ram_byte_sel}, 32'd0);
    check("rsw_bus", {27'b0, bus.resp_valid, bus.resp_err, bus.stall_o, bus.req_ready, 1'b0}, 32'd0);
    check("rsw_addr", ram_addr | ram_wdata, 32'd0);
    nresp = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    check("rsw_noresp", 32'(nresp), 32'd0);
    check("rsw_word0", mem[0], 32'hB2C3D411);
    check("rsw_word4", mem[1], 32'h8877A5BE);
    do_req("rd0c", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hB2C3D411, 1'b0, 2, 1);
    do_req("rd4c", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8877A5BE, 1'b0, 2, 1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
